// File: rtl/pr_ctrl_pkg.sv
// Shared types and defaults for the PR region quiesce controller.
package pr_ctrl_pkg;

   typedef enum logic [2:0] {
      StResetPr,
      StWaitCal,
      StRun,
      StDrain,
      StDecoupled
   } pr_state_e;

   localparam int unsigned OUTS_W_DEF        = 6;
   localparam int unsigned DRAIN_TIMEOUT_DEF = 4096;
   localparam int unsigned RESET_CYCLES_DEF  = 16;

   // One timer serves both the drain window and the reset pulse.
   function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pr_outstanding_cnt.sv
// Request gate and outstanding-burst counter for one AXI address channel.
module pr_outstanding_cnt #(
   parameter int unsigned OUTS_W = 6
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clr,
   input  logic              i_pend_clr,
   input  logic              i_allow,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   input  logic              i_dec,
   output logic              o_pend,
   output logic              o_err,
   output logic [OUTS_W-1:0] o_cnt
);

   logic [OUTS_W-1:0] r_cnt;
   logic              r_pend;
   logic              r_err;
   logic              w_en;
   logic              w_inc;

   // A valid already presented downstream stays open until it handshakes.
   assign w_en      = (i_allow & ~(&r_cnt)) | (r_pend & ~i_pend_clr);
   assign o_m_valid = i_s_valid & w_en;
   assign o_s_ready = i_m_ready & w_en;
   assign w_inc     = o_m_valid & i_m_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt  <= '0;
         r_pend <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (i_clr) begin
            r_cnt <= '0;
         end else if (w_inc & ~i_dec) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (~w_inc & i_dec) begin
            if (r_cnt == '0) begin
               r_err <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
         if (i_pend_clr | i_clr) begin
            r_pend <= 1'b0;
         end else if (o_m_valid) begin
            r_pend <= ~i_m_ready;
         end
      end
   end

   assign o_pend = r_pend;
   assign o_err  = r_err;
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/pr_quiesce_ctrl.sv
// Drains, isolates, resets and recalibrates the DDR4 PR region behind the PCIe AXI slave.
module pr_quiesce_ctrl
   import pr_ctrl_pkg::*;
#(
   parameter int unsigned OUTS_W        = OUTS_W_DEF,
   parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
   parameter int unsigned RESET_CYCLES  = RESET_CYCLES_DEF
) (
   input  logic              i_s_axi_aclk,
   input  logic              i_reset,
   input  logic              i_decouple_req,
   output logic              o_decouple_ack,
   output logic              o_pr_decouple,
   output logic              o_pr_reset,
   input  logic              i_init_calib_complete,
   output logic              o_pr_ready,
   output logic              o_drain_timeout,
   output logic              o_cnt_err,
   output logic [OUTS_W-1:0] o_wr_outstanding,
   output logic [OUTS_W-1:0] o_rd_outstanding,
   input  logic              i_s_awvalid,
   output logic              o_s_awready,
   output logic              o_m_awvalid,
   input  logic              i_m_awready,
   input  logic              i_s_arvalid,
   output logic              o_s_arready,
   output logic              o_m_arvalid,
   input  logic              i_m_arready,
   input  logic              i_bvalid,
   input  logic              i_bready,
   input  logic              i_rvalid,
   input  logic              i_rready,
   input  logic              i_rlast
);

   localparam int unsigned      TMR_W      = tmr_width(DRAIN_TIMEOUT, RESET_CYCLES);
   localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] RESET_LAST = TMR_W'(RESET_CYCLES - 1);

   pr_state_e        r_state;
   pr_state_e        w_state_nxt;
   logic [TMR_W-1:0] r_timer;
   logic             r_pr_reset;
   logic             r_pr_decouple;
   logic             r_pr_ready;
   logic             r_ack;
   logic             r_drain_to;
   logic             w_timeout;
   logic             w_drained;
   logic             w_run;
   logic             w_pend_clr;
   logic             w_cnt_clr;
   logic             w_aw_pend;
   logic             w_ar_pend;
   logic             w_wr_err;
   logic             w_rd_err;

   assign w_run      = (r_state == StRun);
   assign w_pend_clr = (r_state == StDecoupled);
   assign w_cnt_clr  = (r_state == StDecoupled) & (w_state_nxt == StResetPr);
   assign w_drained  = (o_wr_outstanding == '0) & (o_rd_outstanding == '0) &
                       ~w_aw_pend & ~w_ar_pend;

   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      unique case (r_state)
         StResetPr: begin
            if (i_decouple_req)             w_state_nxt = StDecoupled;
            else if (r_timer == RESET_LAST) w_state_nxt = StWaitCal;
         end
         StWaitCal: begin
            if (i_decouple_req)             w_state_nxt = StDecoupled;
            else if (i_init_calib_complete) w_state_nxt = StRun;
         end
         StRun: begin
            if (i_decouple_req) w_state_nxt = StDrain;
         end
         StDrain: begin
            if (!i_decouple_req) begin
               w_state_nxt = StRun;
            end else if (w_drained) begin
               w_state_nxt = StDecoupled;
            end else if (r_timer == DRAIN_LAST) begin
               w_state_nxt = StDecoupled;
               w_timeout   = 1'b1;
            end
         end
         StDecoupled: begin
            if (!i_decouple_req) w_state_nxt = StResetPr;
         end
         default: w_state_nxt = StResetPr;
      endcase
   end

   // Outputs follow the state one cycle late so they leave the block glitch-free.
   always_ff @(posedge i_s_axi_aclk) begin
      if (i_reset) begin
         r_state       <= StResetPr;
         r_timer       <= '0;
         r_pr_reset    <= 1'b1;
         r_pr_decouple <= 1'b1;
         r_pr_ready    <= 1'b0;
         r_ack         <= 1'b0;
         r_drain_to    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_timer       <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
         r_pr_reset    <= (r_state == StResetPr);
         r_pr_decouple <= ~((r_state == StRun) | (r_state == StDrain));
         r_pr_ready    <= (r_state == StRun);
         r_ack         <= (r_state == StDecoupled);
         if (w_timeout) r_drain_to <= 1'b1;
      end
   end

   pr_outstanding_cnt #(
      .OUTS_W (OUTS_W)
   ) u_wr_cnt (
      .i_clk      (i_s_axi_aclk),
      .i_reset    (i_reset),
      .i_clr      (w_cnt_clr),
      .i_pend_clr (w_pend_clr),
      .i_allow    (w_run),
      .i_s_valid  (i_s_awvalid),
      .o_s_ready  (o_s_awready),
      .o_m_valid  (o_m_awvalid),
      .i_m_ready  (i_m_awready),
      .i_dec      (i_bvalid & i_bready),
      .o_pend     (w_aw_pend),
      .o_err      (w_wr_err),
      .o_cnt      (o_wr_outstanding)
   );

   pr_outstanding_cnt #(
      .OUTS_W (OUTS_W)
   ) u_rd_cnt (
      .i_clk      (i_s_axi_aclk),
      .i_reset    (i_reset),
      .i_clr      (w_cnt_clr),
      .i_pend_clr (w_pend_clr),
      .i_allow    (w_run),
      .i_s_valid  (i_s_arvalid),
      .o_s_ready  (o_s_arready),
      .o_m_valid  (o_m_arvalid),
      .i_m_ready  (i_m_arready),
      .i_dec      (i_rvalid & i_rready & i_rlast),
      .o_pend     (w_ar_pend),
      .o_err      (w_rd_err),
      .o_cnt      (o_rd_outstanding)
   );

   assign o_decouple_ack  = r_ack;
   assign o_pr_decouple   = r_pr_decouple;
   assign o_pr_reset      = r_pr_reset;
   assign o_pr_ready      = r_pr_ready;
   assign o_drain_timeout = r_drain_to;
   assign o_cnt_err       = w_wr_err | w_rd_err;

endmodule

// File: tb/tb_pr_quiesce_ctrl.sv
// Directed bench for pr_quiesce_ctrl: bring-up, drain, timeout, pending hold, count error.
module tb_pr_quiesce_ctrl;

   localparam int unsigned OUTS_W = 6;

   logic              clk;
   logic              reset;
   logic              decouple_req;
   logic              decouple_ack;
   logic              pr_decouple;
   logic              pr_reset;
   logic              init_calib_complete;
   logic              pr_ready;
   logic              drain_timeout;
   logic              cnt_err;
   logic [OUTS_W-1:0] wr_outstanding;
   logic [OUTS_W-1:0] rd_outstanding;
   logic              s_awvalid, s_awready, m_awvalid, m_awready;
   logic              s_arvalid, s_arready, m_arvalid, m_arready;
   logic              bvalid, bready, rvalid, rready, rlast;

   int n_checks;
   int n_err;
   int n;
   int pulse;

   pr_quiesce_ctrl #(
      .OUTS_W        (OUTS_W),
      .DRAIN_TIMEOUT (64),
      .RESET_CYCLES  (16)
   ) dut (
      .i_s_axi_aclk          (clk),
      .i_reset               (reset),
      .i_decouple_req        (decouple_req),
      .o_decouple_ack        (decouple_ack),
      .o_pr_decouple         (pr_decouple),
      .o_pr_reset            (pr_reset),
      .i_init_calib_complete (init_calib_complete),
      .o_pr_ready            (pr_ready),
      .o_drain_timeout       (drain_timeout),
      .o_cnt_err             (cnt_err),
      .o_wr_outstanding      (wr_outstanding),
      .o_rd_outstanding      (rd_outstanding),
      .i_s_awvalid           (s_awvalid),
      .o_s_awready           (s_awready),
      .o_m_awvalid           (m_awvalid),
      .i_m_awready           (m_awready),
      .i_s_arvalid           (s_arvalid),
      .o_s_arready           (s_arready),
      .o_m_arvalid           (m_arvalid),
      .i_m_arready           (m_arready),
      .i_bvalid              (bvalid),
      .i_bready              (bready),
      .i_rvalid              (rvalid),
      .i_rready              (rready),
      .i_rlast               (rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      reset = 1'b1; decouple_req = 1'b0; init_calib_complete = 1'b0;
      s_awvalid = 1'b0; m_awready = 1'b0; s_arvalid = 1'b0; m_arready = 1'b0;
      bvalid = 1'b0; bready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;

      // Reset state, with gates closed even when both sides offer a handshake
      repeat (3) tick();
      s_awvalid = 1'b1; m_awready = 1'b1;
      #1;
      chk("rst_pr_reset", pr_reset, 1);
      chk("rst_pr_decouple", pr_decouple, 1);
      chk("rst_pr_ready", pr_ready, 0);
      chk("rst_ack", decouple_ack, 0);
      chk("rst_wr", wr_outstanding, 0);
      chk("rst_rd", rd_outstanding, 0);
      chk("rst_dto", drain_timeout, 0);
      chk("rst_cnt_err", cnt_err, 0);
      chk("rst_m_awvalid", m_awvalid, 0);
      chk("rst_s_awready", s_awready, 0);
      s_awvalid = 1'b0; m_awready = 1'b0;

      // Bring-up: pr_reset through edge 16, calib raised in cycle 40
      reset = 1'b0;
      for (int k = 1; k <= 42; k++) begin
         tick();
         if (k <= 16) chk("bringup_pr_reset_hi", pr_reset, 1);
         if (k == 17) chk("bringup_pr_reset_lo", pr_reset, 0);
         if (k == 40) begin
            chk("bringup_wait_ready", pr_ready, 0);
            chk("bringup_wait_decouple", pr_decouple, 1);
            init_calib_complete = 1'b1;
         end
         if (k == 41) chk("bringup_ready_lag", pr_ready, 0);
         if (k == 42) begin
            chk("bringup_ready", pr_ready, 1);
            chk("bringup_decouple_lo", pr_decouple, 0);
         end
      end

      // Writes in RUN: third AW coincides with first B
      s_awvalid = 1'b1; m_awready = 1'b1;
      #1;
      chk("run_m_awvalid", m_awvalid, 1);
      chk("run_s_awready", s_awready, 1);
      tick(); chk("wr_after_aw1", wr_outstanding, 1);
      tick(); chk("wr_after_aw2", wr_outstanding, 2);
      bvalid = 1'b1; bready = 1'b1;
      tick(); chk("wr_aw_b_same", wr_outstanding, 2);
      s_awvalid = 1'b0;
      tick(); chk("wr_after_b2", wr_outstanding, 1);
      tick(); chk("wr_after_b3", wr_outstanding, 0);
      bvalid = 1'b0; bready = 1'b0;
      chk("wr_cnt_err", cnt_err, 0);

      // Two reads out, drain with RLASTs at +10 and +20
      s_arvalid = 1'b1; m_arready = 1'b1;
      tick(); tick();
      chk("rd_two_out", rd_outstanding, 2);
      s_arvalid = 1'b0; m_arready = 1'b0;
      decouple_req = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k == 1) begin
            s_arvalid = 1'b1; m_arready = 1'b1;
            #1;
            chk("drain_s_arready", s_arready, 0);
            chk("drain_m_arvalid", m_arvalid, 0);
         end
         if (k == 2) chk("drain_pr_ready", pr_ready, 0);
         if (k == 5) chk("drain_rd_held", rd_outstanding, 2);
         if (k == 9 || k == 19) begin
            rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
         end
         if (k == 10 || k == 20) begin
            rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
         end
         if (k == 10) chk("drain_rd_one", rd_outstanding, 1);
         if (k == 20) chk("drain_rd_zero", rd_outstanding, 0);
         if (k == 21) chk("drain_ack_early", decouple_ack, 0);
         if (k == 22) begin
            chk("drain_ack", decouple_ack, 1);
            chk("drain_no_timeout", drain_timeout, 0);
            chk("drain_pr_decouple", pr_decouple, 1);
         end
      end
      s_arvalid = 1'b0; m_arready = 1'b0;

      // Release: 16-cycle reset, one cycle in WAIT_CAL, RUN, ready a cycle later
      decouple_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!pr_ready && n < 40);
      chk("rerun_latency", n, 19);

      // One write never answered: 64 cycles in DRAIN then forced decouple
      s_awvalid = 1'b1; m_awready = 1'b1;
      tick();
      s_awvalid = 1'b0; m_awready = 1'b0;
      chk("to_wr_one", wr_outstanding, 1);
      decouple_req = 1'b1;
      for (int k = 1; k <= 66; k++) begin
         tick();
         if (k == 64) chk("to_not_yet", drain_timeout, 0);
         if (k == 65) begin
            chk("to_flag", drain_timeout, 1);
            chk("to_ack_lag", decouple_ack, 0);
         end
         if (k == 66) begin
            chk("to_ack", decouple_ack, 1);
            chk("to_wr_kept", wr_outstanding, 1);
         end
      end

      // Back to RUN; counters cleared on the way through reset
      decouple_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!pr_ready && n < 40);
      chk("rerun2_latency", n, 19);
      chk("rerun2_wr_clear", wr_outstanding, 0);
      chk("rerun2_dto_sticky", drain_timeout, 1);

      // Stalled AW survives the decouple request until it handshakes
      s_awvalid = 1'b1; m_awready = 1'b0;
      tick();
      chk("pend_m_awvalid", m_awvalid, 1);
      decouple_req = 1'b1;
      tick(); tick();
      chk("pend_held_in_drain", m_awvalid, 1);
      chk("pend_s_awready_lo", s_awready, 0);
      m_awready = 1'b1;
      #1;
      chk("pend_s_awready_hi", s_awready, 1);
      tick();
      chk("pend_wr_one", wr_outstanding, 1);
      chk("pend_gate_closed", m_awvalid, 0);
      s_awvalid = 1'b0; m_awready = 1'b0;

      // Matching B drains, then a stray B at zero is flagged
      bvalid = 1'b1; bready = 1'b1;
      tick();
      bvalid = 1'b0;
      chk("b_wr_zero", wr_outstanding, 0);
      chk("b_no_err", cnt_err, 0);
      tick(); tick();
      chk("b_ack", decouple_ack, 1);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0; bready = 1'b0;
      chk("stray_b_err", cnt_err, 1);
      chk("stray_b_wr", wr_outstanding, 0);

      // Release with calibration low: pulse width, WAIT_CAL, then RUN
      init_calib_complete = 1'b0;
      decouple_req = 1'b0;
      pulse = 0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (pr_reset) pulse++;
         if (k == 1) chk("rel_pulse_start", pr_reset, 0);
         if (k == 22) begin
            chk("rel_wait_ready", pr_ready, 0);
            chk("rel_wait_decouple", pr_decouple, 1);
            chk("rel_wait_pr_reset", pr_reset, 0);
            init_calib_complete = 1'b1;
         end
         if (k == 23) chk("rel_ready_lag", pr_ready, 0);
         if (k == 24) chk("rel_ready", pr_ready, 1);
      end
      chk("rel_pulse_len", pulse, 16);
      chk("rel_err_sticky", cnt_err, 1);

      // Sticky flags clear only on reset
      reset = 1'b1;
      tick();
      chk("final_rst_err", cnt_err, 0);
      chk("final_rst_dto", drain_timeout, 0);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pr_quiesce_ctrl.md
Name: pr_quiesce_ctrl

Overview:
- Sequences safe partial reconfiguration of the DDR4 PR region behind the PCIe AXI slave port (256-bit data, 16-bit address).
- Gates new AW/AR requests from the static side and counts outstanding write and read bursts.
- On a decouple request: drains traffic, asserts static-side isolation, then releases the region through a reset pulse and a wait for DDR4 calibration.
- Sits in the static region between the PCIe AXI master and the PR module boundary.

Parameters:
OUTS_W, 6, width of outstanding-burst counters; max count 2^OUTS_W-1
DRAIN_TIMEOUT, 4096, cycles allowed in DRAIN before forced decouple
RESET_CYCLES, 16, length of pr_reset pulse in cycles

Ports:
s_axi_aclk  in  1  single clock for all logic
reset  in  1  synchronous, active-high
decouple_req  in  1  level request from control register; 1 = decouple PR region
decouple_ack  out  1  1 while PR region is isolated and idle
pr_decouple  out  1  drives static-side isolation of all PR-boundary AXI/DDR signals
pr_reset  out  1  active-high reset to PR region
init_calib_complete  in  1  DDR4 calibration done from PR region
pr_ready  out  1  PR region in service
drain_timeout  out  1  sticky; drain ended by timeout
cnt_err  out  1  sticky; B or RLAST handshake with zero outstanding
wr_outstanding  out  OUTS_W  outstanding write bursts
rd_outstanding  out  OUTS_W  outstanding read bursts
s_awvalid / s_awready  in / out  1  static-side AW handshake
m_awvalid / m_awready  out / in  1  PR-side AW handshake
s_arvalid / s_arready  in / out  1  static-side AR handshake
m_arvalid / m_arready  out / in  1  PR-side AR handshake
bvalid, bready  in  1  B channel monitor
rvalid, rready, rlast  in  1  R channel monitor

Behaviour:
- Clock/reset: one clock s_axi_aclk; reset is synchronous, active-high.
- States: RESET_PR, WAIT_CAL, RUN, DRAIN, DECOUPLED. Reset enters RESET_PR.
- Reset values: pr_decouple=1, pr_reset=1, pr_ready=0, decouple_ack=0, counters=0, drain_timeout=0, cnt_err=0, gates closed.
- Gating (combinational):
  - m_awvalid = s_awvalid & aw_en; s_awready = m_awready & aw_en.
  - aw_en = (state==RUN & wr_outstanding != max) | aw_pend.
  - aw_pend is a registered flag: set when m_awvalid & !m_awready; cleared on handshake. This keeps an issued valid from being withdrawn.
  - AR is identical, using rd_outstanding and ar_pend.
- Counters:
  - wr +1 on m_awvalid & m_awready; -1 on bvalid & bready; both in the same cycle = unchanged.
  - rd +1 on m_arvalid & m_arready; -1 on rvalid & rready & rlast.
  - A decrement at 0 holds the count at 0 and sets cnt_err.
  - Counters are cleared on entry to RESET_PR.
- RUN:
  - pr_ready=1, pr_decouple=0.
  - decouple_req=1 -> DRAIN; the drain timer starts at 0.
- DRAIN:
  - Gates close except pending handshakes; pr_ready=0.
  - wr=rd=0 and no pending -> DECOUPLED.
  - Timer reaches DRAIN_TIMEOUT-1 -> DECOUPLED, set drain_timeout.
  - decouple_req=0 before completion -> RUN (abort).
- DECOUPLED:
  - pr_decouple=1, decouple_ack=1 (registered, asserted the cycle after entry).
  - Pending flags are forcibly cleared.
  - decouple_req=0 -> RESET_PR.
- RESET_PR:
  - pr_reset=1 for exactly RESET_CYCLES cycles, then -> WAIT_CAL.
  - decouple_req=1 -> DECOUPLED immediately.
- WAIT_CAL:
  - pr_reset=0, pr_decouple=1.
  - init_calib_complete=1 -> RUN. pr_ready and pr_decouple=0 update one cycle after the state change (registered outputs).
  - decouple_req=1 -> DECOUPLED.
- Sticky flags clear only on reset.
- Latency:
  - decouple_req to decouple_ack is at least 2 cycles when the region is idle.
  - Gating adds no latency.

Decomposition:
- Shared package pr_ctrl_pkg holds:
  - state enum (RESET_PR, WAIT_CAL, RUN, DRAIN, DECOUPLED);
  - default parameter constants;
  - timer width = clog2(max(DRAIN_TIMEOUT, RESET_CYCLES)).
- One natural sub-module: pr_outstanding_cnt, instantiated twice (write, read). It contains the up/down counter, saturation flag, pending flag, and err flag.

Test Plan:
- Reset deasserted, init_calib_complete rises at cycle 40 -> pr_reset=1 for cycles 1-16, RUN at cycle 41, pr_ready=1 at cycle 42.
- In RUN: 3 AW handshakes, then 3 B handshakes; one AW and one B coincide in one cycle -> wr_outstanding peaks at 2-3 and ends at 0, cnt_err=0.
- 2 reads outstanding, decouple_req=1, RLASTs arrive at +10 and +20 -> s_arready=0 during DRAIN, decouple_ack=1 at +22, drain_timeout=0.
- 1 write outstanding, no B response, DRAIN_TIMEOUT=64 -> DECOUPLED at cycle 64, drain_timeout=1.
- m_awvalid held with m_awready=0, then decouple_req -> m_awvalid stays 1 until handshake, then gate closes.
- bvalid & bready with wr_outstanding=0 -> cnt_err=1, count stays 0. Then decouple_req 1->0 -> a 16-cycle pr_reset pulse, WAIT_CAL, RUN.
